async_fifo_wr_ctrl: RTL
=======================

Name: async_fifo_wr_ctrl

Overview:
- Write-side pointer and flag controller for async_fifo. Runs entirely in the write_clk domain.
- Accepts upstream write requests and generates the binary waddr and qualified write_en that drive the FIFO memory port.
- Publishes a Gray-coded write pointer for the read domain, and synchronizes the read domain's Gray pointer back in to derive full, almost_full and fill level.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 4; must match async_fifo DEPTH.
- ALMOST_FULL_THRESH, 12, almost_full asserts when level >= this value; range 1..DEPTH.
- AW, $clog2(DEPTH), derived localparam; pointers are AW+1 bits.

Ports:
- write_clk  in  1  write-domain clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  upstream requests a write this cycle.
- wr_ready  out  1  equals !full.
- gray_read_ptr  in  AW+1  read-domain Gray pointer; asynchronous to write_clk.
- write_en  out  1  to async_fifo: wr_valid & !full, combinational.
- waddr  out  AW+1  binary write pointer to async_fifo; registered.
- gray_write_ptr  out  AW+1  registered Gray write pointer, for the read domain.
- full  out  1  registered full flag.
- almost_full  out  1  registered flag.
- level  out  AW+1  registered occupancy as seen from the write domain, 0..DEPTH.

Behaviour:
- Reset: clock write_clk; reset rst is synchronous and active-high. On any write_clk edge with rst=1, all of the following clear to 0 regardless of other inputs: waddr, gray_write_ptr, both sync stages, full, almost_full, level. During reset, write_en and wr_ready are 0.
- Mid-operation reset: pointers return to 0 and no write is issued that cycle. The system resets the read side in the same window.
- Handshake: a write is accepted on an edge where wr_valid=1 and full=0. No write when full=1, and the pointer holds.
- Pointer update: wbin_next = waddr + write_en, modulo 2^(AW+1).
  - waddr <= wbin_next.
  - gray_write_ptr <= wbin_next ^ (wbin_next >> 1).
  - Only one bit of gray_write_ptr changes per edge.
- Read-pointer synchronization: 2-flop synchronizer. rq1 <= gray_read_ptr; rq2 <= rq1. No logic between the flops.
- rbin_sync = gray-to-binary of rq2, combinational.
- Full: full <= (gray(wbin_next) == {~rq2[AW:AW-1], rq2[AW-2:0]}).
  - Assertion occurs on the same edge as the write that fills the FIFO, so there is zero-cycle latency to full.
- Full release latency: a read-pointer change stable before edge k is captured in rq1 at k and in rq2 at k+1. full deasserts at edge k+2. The flag is pessimistic and never deasserts early.
- Level and almost_full:
  - level <= wbin_next - rbin_sync, modulo 2^(AW+1).
  - almost_full <= ((wbin_next - rbin_sync) >= ALMOST_FULL_THRESH).
- Wrap-around: the extra MSB distinguishes full from empty when the low AW bits are equal. Pointer wrap from 2^(AW+1)-1 to 0 is seamless.
- Boundary case, wr_valid while full: write_en=0, no state change except flag recomputation.
- Boundary case, simultaneous write and read-pointer advance: the write is accepted using the current full value; the new read pointer affects flags only after synchronization.
- level never exceeds DEPTH.

Decomposition:
- Package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width;
  - a ptr_t typedef helper for AW+1-bit pointers;
  - the shared DEPTH default.
- Sub-module sync_2ff #(WIDTH): a plain two-flop synchronizer with synchronous active-high reset. It is reused for the read-side controller.

Test Plan:
- Reset: hold rst 3 cycles with wr_valid=1 -> waddr=0, gray_write_ptr=0, full=0, write_en=0, level=0.
- Fill: DEPTH=16, gray_read_ptr=0, wr_valid=1 for 20 cycles.
  - Expect exactly 16 write_en pulses and waddr=16 (5'b10000).
  - gray_write_ptr=5'b11000; full=1 on the 16th accepting edge; wr_ready=0 thereafter.
  - almost_full=1 from the 12th accept.
- Full release: from the full state, set gray_read_ptr=bin2gray(1) before edge k -> full stays 1 at edges k and k+1, and is 0 after edge k+2.
  - The next write lands at waddr[3:0]=0.
- Wrap: with a reader mirroring writes, stream 40 writes.
  - waddr wraps 31->0; every consecutive gray_write_ptr pair differs by exactly one bit.
  - full is never set.
- Metastability abstraction: toggle gray_read_ptr asynchronously with a random phase -> level stays within 0..16, and full never deasserts with fewer than the true number of free entries.
- Mid-operation reset: assert rst for 1 cycle at level=9 with wr_valid=1 -> all outputs 0 the next cycle; write_en=0 during reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO controllers: Gray/binary conversion
// and the default geometry.
package fifo_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int PTR_MAX_W     = 32;

    typedef logic [$clog2(DEPTH_DEFAULT):0] ptr_t;

    // Callers zero-extend narrower pointers; leading zeros do not disturb the lower bits.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchronizer for Gray pointers crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= d;
            q2 <= q1;
        end
    end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and flag controller for async_fifo; lives entirely in the
// write_clk domain and sees the read pointer only through a 2-flop synchronizer.
module async_fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH              = DEPTH_DEFAULT,
    parameter int ALMOST_FULL_THRESH = 12,
    localparam int AW                = $clog2(DEPTH)
) (
    input  logic        write_clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [AW:0] gray_read_ptr,
    output logic        write_en,
    output logic [AW:0] waddr,
    output logic [AW:0] gray_write_ptr,
    output logic        full,
    output logic        almost_full,
    output logic [AW:0] level
);

    localparam int PW = AW + 1;

    logic [AW:0] rq1;
    logic [AW:0] rq2;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin_sync;
    logic [AW:0] level_next;
    logic        full_next;
    logic        almost_full_next;

    sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .clk (write_clk),
        .rst (rst),
        .d   (gray_read_ptr),
        .q1  (rq1),
        .q2  (rq2)
    );

    assign wr_ready = ~full & ~rst;
    assign write_en = wr_valid & ~full & ~rst;

    assign wbin_next  = waddr + PW'(write_en);
    assign wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
    assign rbin_sync  = PW'(gray2bin(PTR_MAX_W'(rq2)));

    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next        = (wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]});
    assign level_next       = wbin_next - rbin_sync;
    assign almost_full_next = (PTR_MAX_W'(level_next) >= PTR_MAX_W'(ALMOST_FULL_THRESH));

    always_ff @(posedge write_clk) begin
        if (rst) begin
            waddr          <= '0;
            gray_write_ptr <= '0;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            level          <= '0;
        end else begin
            waddr          <= wbin_next;
            gray_write_ptr <= wgray_next;
            full           <= full_next;
            almost_full    <= almost_full_next;
            level          <= level_next;
        end
    end

endmodule
